// File: rtl/mac_pkg.sv
// Shared types for the MAC lane sequencer: FSM encoding, lane port structs and sizing defaults.
package mac_pkg;

    localparam int MAC_ROWS_DEFAULT  = 64;
    localparam int MAC_ACCUM_DEFAULT = 16;
    localparam int MAC_LANES         = 4;
    localparam int MAC_ELEM_W        = 8;
    localparam int MAC_DATA_W        = MAC_LANES * MAC_ELEM_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_WFM   = 3'd2,
        ST_IFM   = 3'd3,
        ST_DRAIN = 3'd4
    } mac_lane_seq_state_e;

    typedef struct packed {
        logic [MAC_DATA_W-1:0] data;
    } mac_lane_wfm_port;

    typedef struct packed {
        logic [MAC_DATA_W-1:0] data;
        logic [MAC_LANES-1:0]  data_element_valid;
        logic                  inter_end;
        logic                  accum_end;
    } mac_lane_ifm_port;

endpackage

// File: rtl/mac_lane_seq_if.sv
// Upstream and lane-side streaming channels of the sequencer; master is the sequencer itself.
interface mac_lane_seq_if;
    import mac_pkg::*;

    logic             i_bias_valid;
    logic             o_bias_ready;
    logic [31:0]      i_bias;
    logic             i_wfm_valid;
    logic             o_wfm_ready;
    mac_lane_wfm_port i_wfm;
    logic             i_ifm_valid;
    logic             o_ifm_ready;
    mac_lane_ifm_port i_ifm;
    logic             o_lane_bias_valid;
    logic             i_lane_bias_ready;
    logic [31:0]      o_lane_bias;
    logic             o_lane_wfm_valid;
    mac_lane_wfm_port o_lane_wfm;
    logic             o_lane_ifm_valid;
    logic             i_lane_ifm_ready;
    mac_lane_ifm_port o_lane_ifm;
    logic             i_ofm_fire;

    modport master (
        input  i_bias_valid, i_bias, i_wfm_valid, i_wfm, i_ifm_valid, i_ifm,
        input  i_lane_bias_ready, i_lane_ifm_ready, i_ofm_fire,
        output o_bias_ready, o_wfm_ready, o_ifm_ready,
        output o_lane_bias_valid, o_lane_bias, o_lane_wfm_valid, o_lane_wfm,
        output o_lane_ifm_valid, o_lane_ifm
    );

    modport slave (
        output i_bias_valid, i_bias, i_wfm_valid, i_wfm, i_ifm_valid, i_ifm,
        output i_lane_bias_ready, i_lane_ifm_ready, i_ofm_fire,
        input  o_bias_ready, o_wfm_ready, o_ifm_ready,
        input  o_lane_bias_valid, o_lane_bias, o_lane_wfm_valid, o_lane_wfm,
        input  o_lane_ifm_valid, o_lane_ifm
    );

endinterface

// File: rtl/mac_lane_seq.sv
// Sequences one MAC pass: optional bias, then per accumulation set one held weight and a row burst
// of ifm with regenerated end flags, then waits for the lane to emit one ofm row per ifm row.
module mac_lane_seq
    import mac_pkg::*;
#(
    parameter int MAC_ROWS  = MAC_ROWS_DEFAULT,
    parameter int MAC_ACCUM = MAC_ACCUM_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_bias_en,
    input  logic [$clog2(MAC_ROWS)-1:0]  i_rows_m1,
    input  logic [$clog2(MAC_ACCUM)-1:0] i_accum_m1,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [2:0]                   o_state,
    mac_lane_seq_if.master               bus
);

    localparam int ROW_W = $clog2(MAC_ROWS);
    localparam int ACC_W = $clog2(MAC_ACCUM);
    localparam int OFM_W = ROW_W + 1;
    localparam logic [ROW_W-1:0] ROW_ONE = 1;
    localparam logic [ACC_W-1:0] ACC_ONE = 1;
    localparam logic [OFM_W-1:0] OFM_ONE = 1;

    mac_lane_seq_state_e state_reg, state_next;
    logic                bias_en_reg, bias_en_next;
    logic [ROW_W-1:0]    rows_m1_reg, rows_m1_next;
    logic [ACC_W-1:0]    accum_m1_reg, accum_m1_next;
    logic [ROW_W-1:0]    row_cnt_reg, row_cnt_next;
    logic [ACC_W-1:0]    acc_cnt_reg, acc_cnt_next;
    logic [OFM_W-1:0]    ofm_cnt_reg, ofm_cnt_next;
    mac_lane_wfm_port    wfm_reg, wfm_next;
    logic                done_reg, done_next;

    logic             bias_ready, lane_bias_valid, wfm_ready, lane_wfm_valid;
    logic             ifm_ready, lane_ifm_valid, ofm_complete;
    mac_lane_ifm_port lane_ifm;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            bias_en_reg  <= 1'b0;
            rows_m1_reg  <= '0;
            accum_m1_reg <= '0;
            row_cnt_reg  <= '0;
            acc_cnt_reg  <= '0;
            ofm_cnt_reg  <= '0;
            wfm_reg      <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bias_en_reg  <= bias_en_next;
            rows_m1_reg  <= rows_m1_next;
            accum_m1_reg <= accum_m1_next;
            row_cnt_reg  <= row_cnt_next;
            acc_cnt_reg  <= acc_cnt_next;
            ofm_cnt_reg  <= ofm_cnt_next;
            wfm_reg      <= wfm_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bias_en_next    = bias_en_reg;
        rows_m1_next    = rows_m1_reg;
        accum_m1_next   = accum_m1_reg;
        row_cnt_next    = row_cnt_reg;
        acc_cnt_next    = acc_cnt_reg;
        ofm_cnt_next    = ofm_cnt_reg;
        wfm_next        = wfm_reg;
        done_next       = 1'b0;
        bias_ready      = 1'b0;
        lane_bias_valid = 1'b0;
        wfm_ready       = 1'b0;
        lane_wfm_valid  = 1'b0;
        ifm_ready       = 1'b0;
        lane_ifm_valid  = 1'b0;

        lane_ifm           = bus.i_ifm;
        lane_ifm.inter_end = (row_cnt_reg == rows_m1_reg);
        lane_ifm.accum_end = (acc_cnt_reg == accum_m1_reg);

        // Lane output can overlap the last set, so ofm rows are counted in every busy state;
        // the count saturates at rows_m1+1 so it cannot wrap.
        if (state_reg != ST_IDLE && bus.i_ofm_fire && ofm_cnt_reg <= {1'b0, rows_m1_reg})
            ofm_cnt_next = ofm_cnt_reg + OFM_ONE;
        ofm_complete = (ofm_cnt_next > {1'b0, rows_m1_reg});

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    bias_en_next  = i_bias_en;
                    rows_m1_next  = i_rows_m1;
                    accum_m1_next = i_accum_m1;
                    row_cnt_next  = '0;
                    acc_cnt_next  = '0;
                    ofm_cnt_next  = '0;
                    state_next    = i_bias_en ? ST_BIAS : ST_WFM;
                end
            end
            ST_BIAS: begin
                lane_bias_valid = bus.i_bias_valid & bias_en_reg;
                bias_ready      = bus.i_lane_bias_ready & bias_en_reg;
                if (lane_bias_valid && bias_ready)
                    state_next = ST_WFM;
            end
            ST_WFM: begin
                wfm_ready = 1'b1;
                if (bus.i_wfm_valid) begin
                    wfm_next   = bus.i_wfm;
                    state_next = ST_IFM;
                end
            end
            ST_IFM: begin
                lane_wfm_valid = 1'b1;
                lane_ifm_valid = bus.i_ifm_valid;
                ifm_ready      = bus.i_lane_ifm_ready;
                if (bus.i_ifm_valid && bus.i_lane_ifm_ready) begin
                    if (row_cnt_reg != rows_m1_reg) begin
                        row_cnt_next = row_cnt_reg + ROW_ONE;
                    end else if (acc_cnt_reg != accum_m1_reg) begin
                        row_cnt_next = '0;
                        acc_cnt_next = acc_cnt_reg + ACC_ONE;
                        state_next   = ST_WFM;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (ofm_complete) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.o_bias_ready      = bias_ready;
    assign bus.o_lane_bias_valid = lane_bias_valid;
    assign bus.o_lane_bias       = bus.i_bias;
    assign bus.o_wfm_ready       = wfm_ready;
    assign bus.o_lane_wfm_valid  = lane_wfm_valid;
    assign bus.o_lane_wfm        = wfm_reg;
    assign bus.o_ifm_ready       = ifm_ready;
    assign bus.o_lane_ifm_valid  = lane_ifm_valid;
    assign bus.o_lane_ifm        = lane_ifm;

    assign o_busy  = (state_reg != ST_IDLE);
    assign o_done  = done_reg;
    assign o_state = state_reg;

endmodule

// File: tb/tb_mac_lane_seq.sv
// Randomised pass-level bench: a reference model queues expected lane beats, bias and done;
// a negedge monitor pops and compares whenever the sequencer presents a handshake.
module tb_mac_lane_seq;
    import mac_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_bias_en = 1'b0;
    logic [5:0] i_rows_m1 = '0;
    logic [3:0] i_accum_m1 = '0;
    logic       o_busy, o_done;
    logic [2:0] o_state;

    mac_lane_seq_if bus ();

    mac_lane_seq #(.MAC_ROWS(64), .MAC_ACCUM(16)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_bias_en  (i_bias_en),
        .i_rows_m1  (i_rows_m1),
        .i_accum_m1 (i_accum_m1),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_state    (o_state),
        .bus        (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  dev;
        logic        ie;
        logic        ae;
        logic [31:0] wfm;
    } beat_t;

    beat_t            exp_beat_q[$];
    logic [31:0]      exp_bias_q[$];
    logic [31:0]      wfm_src[$];
    mac_lane_ifm_port ifm_src[$];
    beat_t            mb;

    int  n_vec = 0, n_err = 0;
    int  cyc = 0, beats = 0, fires = 0, done_seen = 0, last_evt = 0;
    int  wfm_hs = 0, up_ifm_hs = 0, rows = 1, total = 1;
    bit  pass_active = 0, pass_over = 0, rand_rdy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge i_clk);
            cyc++;
            if (bus.o_lane_bias_valid && bus.i_lane_bias_ready) begin
                if (exp_bias_q.size() == 0) chk("bias_unexpected", 1, 0);
                else chk("bias_data", bus.o_lane_bias, exp_bias_q.pop_front());
            end
            if (bus.i_wfm_valid && bus.o_wfm_ready) wfm_hs++;
            if (bus.i_ifm_valid && bus.o_ifm_ready) up_ifm_hs++;
            if (bus.o_lane_ifm_valid && bus.i_lane_ifm_ready) begin
                beats++;
                last_evt = cyc;
                if (exp_beat_q.size() == 0) chk("ifm_unexpected", 1, 0);
                else begin
                    mb = exp_beat_q.pop_front();
                    chk("ifm_data", bus.o_lane_ifm.data, mb.data);
                    chk("ifm_dev", bus.o_lane_ifm.data_element_valid, mb.dev);
                    chk("inter_end", bus.o_lane_ifm.inter_end, mb.ie);
                    chk("accum_end", bus.o_lane_ifm.accum_end, mb.ae);
                    chk("wfm_held", bus.o_lane_wfm.data, mb.wfm);
                    chk("wfm_valid", bus.o_lane_wfm_valid, 1);
                    chk("ifm_ready_pass", bus.o_ifm_ready, 1);
                end
            end
            if (bus.i_ofm_fire) begin
                fires++;
                last_evt = cyc;
            end
            if (o_done) begin
                done_seen++;
                chk("done_fires", fires, rows);
                chk("done_beats", beats, total);
                chk("done_latency", (cyc - last_evt <= 2), 1);
            end
            if (!pass_active)
                chk("idle_quiet", {bus.o_bias_ready, bus.o_lane_bias_valid, bus.o_wfm_ready,
                                   bus.o_lane_wfm_valid, bus.o_ifm_ready, bus.o_lane_ifm_valid,
                                   o_busy, o_done}, 0);
        end
    end

    task automatic bias_drv(input bit ben, input logic [31:0] bv);
        bit sent = 0, hs;
        while (!pass_over) begin
            if (!bus.i_bias_valid) bus.i_bias_valid = !sent && ($urandom_range(0, 3) != 0);
            bus.i_bias = (ben && !sent) ? bv : $urandom;
            @(negedge i_clk);
            hs = bus.i_bias_valid && bus.o_bias_ready;
            @(posedge i_clk); #1;
            if (hs) begin sent = 1; bus.i_bias_valid = 0; end
        end
        bus.i_bias_valid = 0;
    endtask

    task automatic wfm_drv();
        int k = 0;
        bit hs;
        while (!pass_over) begin
            if (!bus.i_wfm_valid && k < wfm_src.size()) begin
                bus.i_wfm_valid = ($urandom_range(0, 3) != 0);
                bus.i_wfm.data  = bus.i_wfm_valid ? wfm_src[k] : $urandom;
            end
            @(negedge i_clk);
            hs = bus.i_wfm_valid && bus.o_wfm_ready;
            @(posedge i_clk); #1;
            if (hs) begin k++; bus.i_wfm_valid = 0; end
        end
        bus.i_wfm_valid = 0;
    endtask

    task automatic ifm_drv();
        int k = 0;
        bit hs;
        while (!pass_over) begin
            if (!bus.i_ifm_valid && k < ifm_src.size()) begin
                bus.i_ifm_valid = ($urandom_range(0, 3) != 0);
                bus.i_ifm = bus.i_ifm_valid ? ifm_src[k] : mac_lane_ifm_port'({$urandom, $urandom});
            end
            @(negedge i_clk);
            hs = bus.i_ifm_valid && bus.o_ifm_ready;
            @(posedge i_clk); #1;
            if (hs) begin k++; bus.i_ifm_valid = 0; end
        end
        bus.i_ifm_valid = 0;
    endtask

    task automatic rdy_drv();
        while (!pass_over) begin
            bus.i_lane_ifm_ready  = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.i_lane_bias_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(posedge i_clk); #1;
        end
        bus.i_lane_ifm_ready  = 0;
        bus.i_lane_bias_ready = 0;
    endtask

    task automatic ofm_drv(input int thresh);
        int left = rows;
        while (!pass_over && beats < thresh) begin
            @(posedge i_clk); #1;
        end
        while (!pass_over) begin
            bus.i_ofm_fire = (left > 0) && ($urandom_range(0, 1) == 1);
            if (bus.i_ofm_fire) left--;
            @(posedge i_clk); #1;
        end
        bus.i_ofm_fire = 0;
    endtask

    task automatic ctl(input int glitch_beat, input int reset_beat);
        bit glitched = 0;
        int budget = 20000;
        while (budget > 0) begin
            @(posedge i_clk); #1;
            budget--;
            i_start = 0;
            if (done_seen > 0) break;
            if (reset_beat >= 0 && beats >= reset_beat) begin
                i_reset = 1;
                @(negedge i_clk);
                chk("rst_state", o_state, ST_IDLE);
                chk("rst_outputs", {bus.o_bias_ready, bus.o_lane_bias_valid, bus.o_wfm_ready,
                                    bus.o_lane_wfm_valid, bus.o_ifm_ready, bus.o_lane_ifm_valid,
                                    o_busy, o_done}, 0);
                repeat (2) @(posedge i_clk);
                #1 i_reset = 0;
                break;
            end
            if (glitch_beat >= 0 && !glitched && beats >= glitch_beat) begin
                glitched   = 1;
                i_start    = 1;
                i_bias_en  = 1;
                i_rows_m1  = 6'($urandom);
                i_accum_m1 = 4'($urandom);
            end
        end
        if (budget == 0) chk("pass_timeout", 1, 0);
        i_start   = 0;
        pass_over = 1;
    endtask

    task automatic run_pass(input bit ben, input int rm1, input int am1, input int thresh,
                            input int glitch_beat, input int reset_beat);
        beat_t       e;
        logic [31:0] w, bv;
        mac_lane_ifm_port it;
        rows  = rm1 + 1;
        total = rows * (am1 + 1);
        bv    = $urandom;
        if (ben) exp_bias_q.push_back(bv);
        for (int s = 0; s <= am1; s++) begin
            w = $urandom;
            wfm_src.push_back(w);
            for (int r = 0; r <= rm1; r++) begin
                it = mac_lane_ifm_port'({$urandom, $urandom});
                ifm_src.push_back(it);
                e.data = it.data; e.dev = it.data_element_valid;
                e.ie = (r == rm1); e.ae = (s == am1); e.wfm = w;
                exp_beat_q.push_back(e);
            end
        end
        beats = 0; fires = 0; done_seen = 0; wfm_hs = 0; up_ifm_hs = 0; pass_over = 0;
        @(posedge i_clk); #1;
        i_bias_en = ben; i_rows_m1 = 6'(rm1); i_accum_m1 = 4'(am1);
        i_start = 1; pass_active = 1;
        @(posedge i_clk); #1;
        i_start = 0; i_bias_en = 1'($urandom); i_rows_m1 = 6'($urandom); i_accum_m1 = 4'($urandom);
        fork
            bias_drv(ben, bv);
            wfm_drv();
            ifm_drv();
            rdy_drv();
            ofm_drv(thresh);
            ctl(glitch_beat, reset_beat);
        join
        repeat (4) @(posedge i_clk);
        #1;
        if (reset_beat < 0) begin
            chk("done_count", done_seen, 1);
            chk("beats_missing", exp_beat_q.size(), 0);
            chk("bias_missing", exp_bias_q.size(), 0);
            chk("wfm_handshakes", wfm_hs, am1 + 1);
            chk("ifm_handshakes", up_ifm_hs, total);
        end else begin
            chk("rst_no_done", done_seen, 0);
        end
        $display("pass bias_en=%0d rows=%0d sets=%0d beats=%0d fires=%0d done=%0d",
                 ben, rows, am1 + 1, beats, fires, done_seen);
        exp_beat_q.delete(); exp_bias_q.delete(); wfm_src.delete(); ifm_src.delete();
        pass_active = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rm1, am1;
        bus.i_bias_valid = 0; bus.i_bias = '0; bus.i_wfm_valid = 0; bus.i_wfm = '0;
        bus.i_ifm_valid = 0; bus.i_ifm = '0; bus.i_lane_bias_ready = 0;
        bus.i_lane_ifm_ready = 0; bus.i_ofm_fire = 0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_state", o_state, ST_IDLE);
        chk("reset_busy_done", {o_busy, o_done}, 0);
        @(posedge i_clk); #1 i_reset = 0;

        rand_rdy = 0;
        run_pass(1, 63, 2, 192, -1, -1);
        run_pass(0, 0, 0, 1, -1, -1);

        rand_rdy = 1;
        for (int p = 0; p < 6; p++) begin
            rm1 = $urandom_range(0, 15);
            am1 = $urandom_range(0, 3);
            run_pass(1'($urandom), rm1, am1, am1 * (rm1 + 1) + $urandom_range(0, rm1), -1, -1);
        end
        run_pass(1, 7, 3, 30, 4, -1);
        run_pass(1, 15, 2, 40, -1, 26);
        run_pass(0, 15, 2, 36, -1, -1);
        run_pass(1, 63, 15, 15 * 64 + 10, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
